gray_decoder_checker: RTL and testbench
=======================================

Name: gray_decoder_checker

Overview:
- Receive-side companion to the team's binary-to-Gray counter: samples a Gray-coded count bus, decodes it back to binary and checks that consecutive samples form a legal up-count sequence.
- Declares lock after a run of good increments; flags and counts sequence errors.
- Sits on the consumer side of any Gray-coded count bus, such as a counter output or a pointer crossing a domain.

Parameters:
- WIDTH, 5, width of the Gray input and binary output.
- LOCK_COUNT, 4, consecutive good increments required to enter LOCKED (must be 1 or more).
- ERRW, 8, width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all state.
- enable  input  1  sample strobe; gray_in is captured only when 1.
- gray_in  input  WIDTH  Gray-coded count.
- clr_err  input  1  synchronous clear of err_count.
- bin_out  output  WIDTH  decoded binary of the last accepted sample.
- valid  output  1  one-cycle pulse when bin_out updates.
- error  output  1  one-cycle pulse for an illegal transition.
- locked  output  1  high while in LOCKED.
- err_count  output  ERRW  saturating count of errors.

Behaviour:
- Reset (async, active-high):
  - bin_out=0, valid=0, error=0, locked=0, err_count=0.
  - Internal prev_bin=0, match_cnt=0, stage-1 valid=0, state=SEARCH.
- Stage 1 (input register):
  - enable=1: register gray_in and set s1_valid=1.
  - enable=0: s1_valid=0 and the register holds.
- Stage 2 (decode and check) acts only when s1_valid=1.
  - Decode: b[WIDTH-1]=g[WIDTH-1]; b[i]=b[i+1]^g[i] for i from WIDTH-2 down to 0.
  - Register bin_out=b and pulse valid.
- Latency: a sample taken at edge N gives bin_out, valid, error, locked and err_count updates at edge N+1.
- Transition classes, with prev_bin the last accepted binary value:
  - GOOD: b == prev_bin+1 mod 2^WIDTH. Wrap from all-ones to 0 is GOOD.
  - HOLD: b == prev_bin. Legal; no error, match_cnt unchanged.
  - BAD: anything else.
  - prev_bin is set to b on every accepted sample, including BAD samples, which resyncs tracking.
- State machine:
  - SEARCH: the first accepted sample loads prev_bin with no check, no error and match_cnt=0, then goes to TRACK.
  - TRACK, GOOD: match_cnt+1. When it reaches LOCK_COUNT, go to LOCKED and set locked=1 on that edge.
  - TRACK, HOLD: no change.
  - TRACK, BAD: error pulse, match_cnt=0, stay in TRACK.
  - LOCKED, GOOD or HOLD: stay in LOCKED.
  - LOCKED, BAD: error pulse, locked=0, match_cnt=0, go to TRACK.
- err_count:
  - Increments on every error pulse.
  - Saturates at 2^ERRW-1.
  - clr_err=1 sets it to 0. If clr_err and an error coincide, clear wins and the coincident error is not counted; the error pulse still fires.
- enable=0 for any duration: no pulses, state and outputs hold, no timeout.
- Reset asserted mid-stream: immediate return to reset values. After release the first sample is handled as SEARCH, so a pre-reset prev_bin never produces an error.

Test Plan:
- Reset release, enable=1, gray_in 00000,00001,00011,00010,00110 on consecutive cycles:
  - bin_out 0,1,2,3,4, each one cycle after its sample, with valid high each of those cycles.
  - locked rises with bin_out=4 (4 GOOD transitions); error never set.
- While locked, feed 10001 (bin 30), 10000 (bin 31), 00000 (bin 0): wrap 31->0 is GOOD and locked stays 1.
- While locked at bin 3 (00010), feed 00111 (bin 5):
  - error pulses once, locked falls, err_count=1, state is TRACK.
  - Then 00101 (bin 6) is GOOD, match_cnt=1, and locked stays 0.
- Repeat 00011 three times, then toggle enable low for 5 cycles: HOLD gives no error, and valid is 0 whenever enable=0.
- With ERRW=2, inject 5 BAD samples: err_count reads 1,2,3,3,3. Asserting clr_err on the 5th error gives err_count=0 with the error pulse still present.
- Assert reset asynchronously between edges while locked: outputs go to 0 without waiting for a clock edge. Then feed 01000 (bin 15): no error, state is TRACK.

Source files
------------

// File: rtl/gray_decoder_checker.sv
// gray_decoder_checker: samples a Gray-coded count bus, decodes it to binary
// and checks that consecutive accepted samples form a legal up-count.
// Declares lock after LOCK_COUNT good increments in a row and keeps a
// saturating count of sequence errors.
module gray_decoder_checker #(
  parameter int WIDTH      = 5,
  parameter int LOCK_COUNT = 4,
  parameter int ERRW       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             clr_err,
  output logic [WIDTH-1:0] bin_out,
  output logic             valid,
  output logic             error,
  output logic             locked,
  output logic [ERRW-1:0]  err_count
);

  // Match counter only has to reach LOCK_COUNT.
  localparam int MW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam logic [MW-1:0] LOCK_TARGET = MW'(LOCK_COUNT);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [WIDTH-1:0]  s1_gray_reg;
  logic              s1_valid_reg;
  logic [WIDTH-1:0]  prev_bin_reg;
  logic [MW-1:0]     match_cnt_reg, match_cnt_next;
  logic [ERRW-1:0]   err_count_reg, err_count_next;
  logic [WIDTH-1:0]  bin_reg;
  logic              valid_reg;
  logic              error_reg;
  logic              err_pulse;
  logic [WIDTH-1:0]  dec_bin;
  logic [WIDTH-1:0]  prev_plus_one;
  logic [MW-1:0]     match_inc;
  logic              is_good;
  logic              is_hold;

  // Each binary bit is the XOR of all Gray bits at or above it; written as a
  // reduction per bit so there is no bit-to-bit combinational chain.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_decode
      assign dec_bin[gi] = ^s1_gray_reg[WIDTH-1:gi];
    end
  endgenerate

  // Natural wrap of the WIDTH-bit add makes all-ones -> 0 a good step.
  assign prev_plus_one = prev_bin_reg + WIDTH'(1);
  assign is_good       = (dec_bin == prev_plus_one);
  assign is_hold       = (dec_bin == prev_bin_reg);
  assign match_inc     = match_cnt_reg + MW'(1);

  // Input register: capture the bus only on the sample strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_gray_reg  <= '0;
      s1_valid_reg <= 1'b0;
    end else begin
      s1_valid_reg <= enable;
      if (enable) begin
        s1_gray_reg <= gray_in;
      end
    end
  end

  // Next-state, match counter and error decision for the decoded sample.
  always_comb begin
    state_next     = state_reg;
    match_cnt_next = match_cnt_reg;
    err_pulse      = 1'b0;
    if (s1_valid_reg) begin
      case (state_reg)
        SEARCH: begin
          // First sample after reset only seeds the tracker.
          state_next     = TRACK;
          match_cnt_next = '0;
        end
        TRACK: begin
          if (is_good) begin
            match_cnt_next = match_inc;
            if (match_inc == LOCK_TARGET) begin
              state_next = LOCKED;
            end
          end else if (!is_hold) begin
            err_pulse      = 1'b1;
            match_cnt_next = '0;
          end
        end
        LOCKED: begin
          if (!is_good && !is_hold) begin
            err_pulse      = 1'b1;
            match_cnt_next = '0;
            state_next     = TRACK;
          end
        end
        default: begin
          state_next     = SEARCH;
          match_cnt_next = '0;
        end
      endcase
    end
  end

  // Saturating error counter; a clear beats a coincident error.
  always_comb begin
    err_count_next = err_count_reg;
    if (clr_err) begin
      err_count_next = '0;
    end else if (err_pulse && (err_count_reg != {ERRW{1'b1}})) begin
      err_count_next = err_count_reg + ERRW'(1);
    end
  end

  // Decode/check stage registers and one-cycle output pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= SEARCH;
      prev_bin_reg  <= '0;
      match_cnt_reg <= '0;
      err_count_reg <= '0;
      bin_reg       <= '0;
      valid_reg     <= 1'b0;
      error_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      match_cnt_reg <= match_cnt_next;
      err_count_reg <= err_count_next;
      valid_reg     <= s1_valid_reg;
      error_reg     <= err_pulse;
      if (s1_valid_reg) begin
        // Every accepted sample, even a bad one, resyncs the tracker.
        bin_reg      <= dec_bin;
        prev_bin_reg <= dec_bin;
      end
    end
  end

  assign bin_out   = bin_reg;
  assign valid     = valid_reg;
  assign error     = error_reg;
  assign locked    = (state_reg == LOCKED);
  assign err_count = err_count_reg;

endmodule

// File: tb/tb_gray_decoder_checker.sv
// Testbench for gray_decoder_checker: directed test-plan sequence followed by
// randomized traffic, all compared against an arithmetic reference model.
module tb_gray_decoder_checker;

  localparam int W    = 5;
  localparam int LC   = 4;
  localparam int EW   = 2;
  localparam int MOD  = 1 << W;
  localparam int EMAX = (1 << EW) - 1;

  logic          clk;
  logic          reset;
  logic          enable;
  logic [W-1:0]  gray_in;
  logic          clr_err;
  logic [W-1:0]  bin_out;
  logic          valid;
  logic          error;
  logic          locked;
  logic [EW-1:0] err_count;

  int n_total;
  int n_pass;

  // Reference model state
  bit m_s1_v;
  int m_s1_g;
  bit m_seen;
  int m_prev;
  int m_run;
  bit m_locked;
  int m_err;
  int e_bin;
  bit e_valid;
  bit e_error;

  gray_decoder_checker #(.WIDTH(W), .LOCK_COUNT(LC), .ERRW(EW)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .gray_in   (gray_in),
    .clr_err   (clr_err),
    .bin_out   (bin_out),
    .valid     (valid),
    .error     (error),
    .locked    (locked),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int to_gray(input int b);
    return (b ^ (b >> 1)) % MOD;
  endfunction

  function automatic int from_gray(input int g);
    int b;
    b = 0;
    for (int s = 0; s < W; s++) b = b ^ (g >> s);
    return b % MOD;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_s1_v = 0; m_s1_g = 0; m_seen = 0; m_prev = 0;
    m_run = 0; m_locked = 0; m_err = 0;
    e_bin = 0; e_valid = 0; e_error = 0;
  endtask

  // One clock edge of the reference model, applied with the inputs sampled there.
  task automatic model_edge(input bit en, input int g, input bit clr);
    int b;
    e_valid = 0;
    e_error = 0;
    if (m_s1_v) begin
      b = from_gray(m_s1_g);
      e_bin = b;
      e_valid = 1;
      if (!m_seen) begin
        m_seen = 1;
        m_run = 0;
      end else if (b == (m_prev + 1) % MOD) begin
        if (!m_locked) begin
          m_run++;
          if (m_run == LC) m_locked = 1;
        end
      end else if (b != m_prev) begin
        e_error = 1;
        m_run = 0;
        m_locked = 0;
      end
      m_prev = b;
    end
    if (clr) m_err = 0;
    else if (e_error && m_err < EMAX) m_err++;
    m_s1_v = en;
    if (en) m_s1_g = g;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".bin_out"},   32'(bin_out),   32'(e_bin));
    check({tag, ".valid"},     32'(valid),     32'(e_valid));
    check({tag, ".error"},     32'(error),     32'(e_error));
    check({tag, ".locked"},    32'(locked),    32'(m_locked));
    check({tag, ".err_count"}, 32'(err_count), 32'(m_err));
    $display("[%0t] %s en=%0b g=%b clr=%0b -> bin=%0d valid=%0b error=%0b locked=%0b errcnt=%0d",
             $time, tag, enable, gray_in, clr_err, bin_out, valid, error, locked, err_count);
  endtask

  task automatic cycle(input string tag, input bit en, input int g, input bit clr);
    @(negedge clk);
    enable  = en;
    gray_in = W'(g);
    clr_err = clr;
    @(posedge clk);
    model_edge(en, g, clr);
    #1;
    check_all(tag);
  endtask

  initial begin
    int bad_vals[5];
    int pick;
    int gv;
    n_total = 0;
    n_pass  = 0;
    reset   = 1'b1;
    enable  = 1'b0;
    gray_in = '0;
    clr_err = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;

    // Count 0..4 and lock
    cycle("cnt0", 1, 5'b00000, 0);
    cycle("cnt1", 1, 5'b00001, 0);
    cycle("cnt2", 1, 5'b00011, 0);
    cycle("cnt3", 1, 5'b00010, 0);
    cycle("cnt4", 1, 5'b00110, 0);
    cycle("cnt4o", 1, 5'b00110, 0);
    check("first_lock.bin", 32'(bin_out), 32'd4);
    check("first_lock.locked", 32'(locked), 32'd1);

    // Jump forward in a legal way is not possible; walk up to 29 then wrap
    for (int b = 5; b < 30; b++) cycle("walk", 1, to_gray(b), 0);
    cycle("b30", 1, 5'b10001, 0);
    cycle("b31", 1, 5'b10000, 0);
    cycle("wrap0", 1, 5'b00000, 0);
    cycle("b1", 1, 5'b00001, 0);
    check("wrap.locked", 32'(locked), 32'd1);
    cycle("b2", 1, 5'b00011, 0);
    cycle("b3", 1, 5'b00010, 0);

    // Bad jump 3 -> 5 while locked, then good 5 -> 6
    cycle("bad5", 1, 5'b00111, 0);
    cycle("good6", 1, 5'b00101, 0);
    check("badjump.error", 32'(error), 32'd1);
    check("badjump.err_count", 32'(err_count), 32'd1);
    cycle("after6", 1, 5'b00011, 0);
    check("good6.locked", 32'(locked), 32'd0);

    // Holds of bin 2, then idle enable
    cycle("hold", 1, 5'b00011, 0);
    cycle("hold", 1, 5'b00011, 0);
    for (int i = 0; i < 5; i++) cycle("idle", 0, 5'b11111, 0);

    // Clear the counter, then saturate it with ERRW=2
    cycle("clr", 0, 0, 1);
    bad_vals[0] = 10; bad_vals[1] = 20; bad_vals[2] = 10;
    bad_vals[3] = 20; bad_vals[4] = 10;
    for (int i = 0; i < 5; i++) cycle("bad", 1, to_gray(bad_vals[i]), 0);
    cycle("bad5clr", 1, to_gray(11), 1);
    check("sat_clr.error", 32'(error), 32'd1);
    check("sat_clr.err_count", 32'(err_count), 32'd0);

    // Relock at 11..15
    for (int b = 12; b < 17; b++) cycle("relock", 1, to_gray(b), 0);

    // Asynchronous reset between edges
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    enable = 1'b0;
    cycle("post15", 1, 5'b01000, 0);
    cycle("post16", 1, to_gray(16), 0);
    cycle("post17", 0, 0, 0);

    // Randomized traffic
    gv = 17;
    for (int i = 0; i < 400; i++) begin
      pick = $urandom_range(0, 9);
      if (pick < 6) gv = (gv + 1) % MOD;
      else if (pick == 9) gv = $urandom_range(0, MOD - 1);
      cycle("rand", ($urandom_range(0, 4) != 0), to_gray(gv), ($urandom_range(0, 15) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
